uart_tx_cfg: RTL and testbench
==============================

UART_TX_CFG -- requirements
Module: uart_tx_cfg

Interface
REQ-001 The block SHALL have parameter DBIT, default 8, giving data bits per frame (legal 5..8).
REQ-002 The block SHALL have parameter OVS, default 16, giving baud ticks per bit.
REQ-003 The block SHALL have parameter DIV_W, default 16, giving divisor width.
REQ-004 clk  in  1  single clock; all logic on posedge.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 divisor  in  DIV_W  baud tick period minus one, in clk cycles.
REQ-007 parity_mode  in  2  00 none, 01 even, 10 odd, 11 treated as none.
REQ-008 stop2  in  1  0 gives one stop bit, 1 gives two.
REQ-009 tx_valid  in  1  request to send tx_data.
REQ-010 tx_data  in  DBIT  frame payload.
REQ-011 tx_ready  out  1  high only in IDLE; accept when tx_valid && tx_ready.
REQ-012 tx_busy  out  1  high from the cycle after accept until return to IDLE.
REQ-013 tx_done  out  1  one-cycle pulse in the last clk of the final stop bit.
REQ-014 tx  out  1  serial line, registered, idle high.

Function
REQ-015 The FSM SHALL have states IDLE, START, DATA, PARITY, STOP: IDLE->START on accept; START->DATA after one bit; DATA->PARITY (parity enabled) or STOP after DBIT bits; PARITY->STOP after one bit; STOP->IDLE after 1 or 2 bits.
REQ-016 On accept, tx_data, divisor, parity_mode and stop2 SHALL be latched; input changes mid-frame SHALL have no effect.
REQ-017 The baud counter SHALL clear on accept and pulse a tick every divisor+1 clks; divisor=0 gives a tick every clk.
REQ-018 Each bit SHALL last exactly OVS ticks, i.e. OVS*(divisor+1) clks.
REQ-019 tx SHALL go low in the clk after accept.
REQ-020 Data SHALL be sent LSB first.
REQ-021 The parity bit SHALL be XOR of the latched data for even parity and its inverse for odd parity.
REQ-022 tx SHALL be 1 during STOP and IDLE.
REQ-023 tx_valid while tx_ready=0 SHALL be ignored and not queued.
REQ-024 Back-to-back frames SHALL be separated by exactly one IDLE clk: tx_done, then IDLE with tx_ready=1, accept, then START.
REQ-025 Bit-counter and tick-counter widths SHALL be sized with clog2 of DBIT and OVS; no counter shall wrap within a frame.

Reset
REQ-026 Asserting reset SHALL immediately set state=IDLE, tx=1, tx_ready=1, tx_busy=0, tx_done=0 and clear all counters, including mid-frame; the aborted frame is lost.
REQ-027 The first accept SHALL be possible in the first clk edge after reset deasserts.

Structure
REQ-028 Package uart_pkg SHALL hold the parity_mode enum (PAR_NONE, PAR_EVEN, PAR_ODD) and the tx state enum.
REQ-029 The baud tick generator SHALL be a sub-module uart_baud_gen (inputs clk, reset, clear, divisor; output tick), reusable by the receiver.

Verification (DBIT=8, OVS=16)
REQ-030 divisor=0, parity none, stop2=0, send 0x55: tx = 0 then 1,0,1,0,1,0,1,0 then 1, 16 clks per bit; tx_done at clk 160 after accept.
REQ-031 divisor=0, even parity, send 0x07: parity bit=1; with odd parity the same byte gives 0; frame is 176 clks.
REQ-032 divisor=3, stop2=1, parity none, send 0xA3: each bit is 64 clks; frame is 704 clks; tx_busy high throughout.
REQ-033 tx_valid held high with 0x11 then 0x22: two frames with exactly one tx-high clk between tx_done and the next start bit; the second byte is sampled only at its accept.
REQ-034 Assert reset in the 3rd data bit of 0xF0: tx=1 and tx_ready=1 asynchronously; no tx_done; the next frame after release is correct.
REQ-035 Change divisor and parity_mode mid-frame: the frame timing and parity bit are unchanged; the new config applies on the next accept.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART types: parity selection and transmitter state encoding.
// Also holds the parity helpers used by the transmitter.
package uart_pkg;

   typedef enum logic [1:0] {
      PAR_NONE = 2'b00,
      PAR_EVEN = 2'b01,
      PAR_ODD  = 2'b10
   } parity_t;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
      ST_PARITY = 3'd3,
      ST_STOP   = 3'd4
   } tx_state_t;

   // Mode 2'b11 carries no parity bit, the same as PAR_NONE.
   function automatic logic parity_on(input logic [1:0] mode);
      return (mode == PAR_EVEN) || (mode == PAR_ODD);
   endfunction

   function automatic logic parity_bit(input logic data_xor, input logic [1:0] mode);
      return data_xor ^ (mode == PAR_ODD);
   endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Baud tick generator: one-clk tick every divisor+1 clks, restartable via clear.
// Shared by the UART transmitter and receiver.
module uart_baud_gen #(
   parameter int DIV_W = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clear,
   input  logic [DIV_W-1:0] divisor,
   output logic             tick
);

   logic [DIV_W-1:0] cnt;

   assign tick = (cnt == divisor);

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         cnt <= '0;
      else if (clear || tick)
         cnt <= '0;
      else
         cnt <= cnt + 1'b1;
   end

endmodule

// File: rtl/uart_tx_cfg.sv
// Configurable UART transmitter: per-frame latched divisor, parity and stop count.
// Each bit lasts OVS baud ticks; tx is registered and idles high.
module uart_tx_cfg
   import uart_pkg::*;
#(
   parameter int DBIT  = 8,
   parameter int OVS   = 16,
   parameter int DIV_W = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [DIV_W-1:0] divisor,
   input  logic [1:0]       parity_mode,
   input  logic             stop2,
   input  logic             tx_valid,
   input  logic [DBIT-1:0]  tx_data,
   output logic             tx_ready,
   output logic             tx_busy,
   output logic             tx_done,
   output logic             tx
);

   localparam int TW = (OVS > 1) ? $clog2(OVS) : 1;
   localparam int BW = (DBIT > 1) ? $clog2(DBIT) : 1;
   localparam logic [TW-1:0] T_LAST = TW'(OVS - 1);
   localparam logic [BW-1:0] B_LAST = BW'(DBIT - 1);

   tx_state_t        state;
   logic [DBIT-1:0]  shreg;
   logic [DIV_W-1:0] div_q;
   logic             par_en_q;
   logic             par_q;
   logic             stop2_q;
   logic [TW-1:0]    tcnt;
   logic [BW-1:0]    bcnt;
   logic             sidx;
   logic             tick;
   logic             accept;
   logic             bit_end;

   assign tx_ready = (state == ST_IDLE);
   assign tx_busy  = !tx_ready;
   assign accept   = tx_ready && tx_valid;
   assign bit_end  = tick && (tcnt == T_LAST);
   assign tx_done  = (state == ST_STOP) && bit_end && (sidx == stop2_q);

   uart_baud_gen #(
      .DIV_W(DIV_W)
   ) u_baud (
      .clk     (clk),
      .reset   (reset),
      .clear   (accept),
      .divisor (div_q),
      .tick    (tick)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= ST_IDLE;
         tx       <= 1'b1;
         shreg    <= '0;
         div_q    <= '0;
         par_en_q <= 1'b0;
         par_q    <= 1'b0;
         stop2_q  <= 1'b0;
         tcnt     <= '0;
         bcnt     <= '0;
         sidx     <= 1'b0;
      end else begin
         if (state == ST_IDLE) begin
            tcnt <= '0;
            if (tx_valid) begin
               // Parity is resolved at accept so later mode changes cannot leak in.
               shreg    <= tx_data;
               div_q    <= divisor;
               par_en_q <= parity_on(parity_mode);
               par_q    <= parity_bit(^tx_data, parity_mode);
               stop2_q  <= stop2;
               state    <= ST_START;
               tx       <= 1'b0;
            end
         end else if (tick) begin
            tcnt <= bit_end ? '0 : tcnt + 1'b1;
         end

         if (bit_end) begin
            case (state)
               ST_START: begin
                  state <= ST_DATA;
                  tx    <= shreg[0];
                  bcnt  <= '0;
               end
               ST_DATA: begin
                  if (bcnt == B_LAST) begin
                     sidx <= 1'b0;
                     if (par_en_q) begin
                        state <= ST_PARITY;
                        tx    <= par_q;
                     end else begin
                        state <= ST_STOP;
                        tx    <= 1'b1;
                     end
                  end else begin
                     bcnt  <= bcnt + 1'b1;
                     shreg <= shreg >> 1;
                     tx    <= shreg[1];
                  end
               end
               ST_PARITY: begin
                  state <= ST_STOP;
                  tx    <= 1'b1;
                  sidx  <= 1'b0;
               end
               ST_STOP: begin
                  if (sidx == stop2_q)
                     state <= ST_IDLE;
                  else
                     sidx <= 1'b1;
               end
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Directed self-checking bench for uart_tx_cfg (DBIT=8, OVS=16).
// Expected frames are built from hand-derived bit lists and frame lengths.
module tb_uart_tx_cfg;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [15:0] divisor = '0;
   logic [1:0]  parity_mode = '0;
   logic        stop2 = 1'b0;
   logic        tx_valid = 1'b0;
   logic [7:0]  tx_data = '0;
   logic        tx_ready;
   logic        tx_busy;
   logic        tx_done;
   logic        tx;

   int n_cmp = 0;
   int n_err = 0;
   int pcnt = 0;
   int done_cnt = 0;
   int done_cyc = 0;
   int acc = 0;
   int dc_save = 0;
   int prev_done = 0;

   always #5 clk = ~clk;

   uart_tx_cfg #(
      .DBIT  (8),
      .OVS   (16),
      .DIV_W (16)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .divisor     (divisor),
      .parity_mode (parity_mode),
      .stop2       (stop2),
      .tx_valid    (tx_valid),
      .tx_data     (tx_data),
      .tx_ready    (tx_ready),
      .tx_busy     (tx_busy),
      .tx_done     (tx_done),
      .tx          (tx)
   );

   always @(posedge clk) pcnt <= pcnt + 1;

   always @(negedge clk) begin
      if (tx_done === 1'b1) begin
         done_cnt = done_cnt + 1;
         done_cyc = pcnt;
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL timeout: observed no finish, required finish before 1ms");
      $fatal(1, "timeout");
   end

   task automatic chk(input logic [31:0] obs, input logic [31:0] exp, input string tag);
      n_cmp = n_cmp + 1;
      assert (obs === exp) else begin
         n_err = n_err + 1;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Drives one accept; returns 1ns after the accept edge.
   task automatic send(input logic [7:0] d, input logic [15:0] div, input logic [1:0] pm,
                       input logic s2, input logic hold);
      @(negedge clk);
      tx_data     = d;
      divisor     = div;
      parity_mode = pm;
      stop2       = s2;
      tx_valid    = 1'b1;
      chk(32'(tx_ready), 32'd1, "ready_before_accept");
      @(posedge clk);
      #1;
      if (!hold) tx_valid = 1'b0;
      acc = pcnt;
      chk(32'(tx), 32'd0, "start_low_after_accept");
      chk(32'(tx_busy), 32'd1, "busy_after_accept");
      chk(32'(tx_ready), 32'd0, "ready_low_after_accept");
   endtask

   // par < 0 means no parity bit; L is clks per bit. Starts 1ns after accept.
   task automatic check_frame(input logic [7:0] d, input int par, input int nstop,
                              input int L, input string tag);
      logic bits [0:15];
      int   n;
      int   dc0;
      dc0 = done_cnt;
      bits[0] = 1'b0;
      for (int k = 0; k < 8; k++) bits[k+1] = d[k];
      n = 9;
      if (par >= 0) begin
         bits[n] = par[0];
         n = n + 1;
      end
      for (int k = 0; k < nstop; k++) begin
         bits[n] = 1'b1;
         n = n + 1;
      end
      for (int i = 0; i < n; i++) begin
         repeat (L / 2) @(posedge clk);
         #1;
         chk(32'(tx), 32'(bits[i]), $sformatf("%s_bit%0d", tag, i));
         chk(32'(tx_busy), 32'd1, $sformatf("%s_busy%0d", tag, i));
         repeat (L - L / 2) @(posedge clk);
      end
      #1;
      chk(32'(tx_ready), 32'd1, {tag, "_ready_at_end"});
      chk(32'(tx), 32'd1, {tag, "_idle_high"});
      chk(32'(done_cnt), 32'(dc0 + 1), {tag, "_done_count"});
      chk(32'(done_cyc - acc + 1), 32'(n * L), {tag, "_done_clk"});
   endtask

   initial begin
      #12;
      chk(32'(tx), 32'd1, "rst_tx");
      chk(32'(tx_ready), 32'd1, "rst_ready");
      chk(32'(tx_busy), 32'd0, "rst_busy");
      chk(32'(tx_done), 32'd0, "rst_done");
      @(posedge clk);
      #1 reset = 1'b0;

      // 0x55, no parity, one stop; a late tx_valid pulse mid-frame must not queue.
      send(8'h55, 16'd0, 2'b00, 1'b0, 1'b0);
      fork
         begin
            repeat (20) @(posedge clk);
            #2;
            tx_data  = 8'h00;
            tx_valid = 1'b1;
            repeat (5) @(posedge clk);
            #2 tx_valid = 1'b0;
         end
      join_none
      check_frame(8'h55, -1, 1, 16, "f55");
      dc_save = done_cnt;
      repeat (20) @(posedge clk);
      #1;
      chk(32'(tx_ready), 32'd1, "not_queued_ready");
      chk(32'(tx), 32'd1, "not_queued_tx");
      chk(32'(done_cnt), 32'(dc_save), "not_queued_done");

      // 0x07 has three ones: even parity bit 1, odd parity bit 0.
      send(8'h07, 16'd0, 2'b01, 1'b0, 1'b0);
      check_frame(8'h07, 1, 1, 16, "even07");
      send(8'h07, 16'd0, 2'b10, 1'b0, 1'b0);
      check_frame(8'h07, 0, 1, 16, "odd07");
      send(8'h07, 16'd0, 2'b11, 1'b0, 1'b0);
      check_frame(8'h07, -1, 1, 16, "mode3_07");

      // divisor 3 -> 64 clks per bit, 11 bits -> 704 clks.
      send(8'hA3, 16'd3, 2'b00, 1'b1, 1'b0);
      check_frame(8'hA3, -1, 2, 64, "a3_div3");

      // Back-to-back with tx_valid held; second byte appears only after first accept.
      send(8'h11, 16'd0, 2'b00, 1'b0, 1'b1);
      tx_data = 8'h22;
      check_frame(8'h11, -1, 1, 16, "b2b_first");
      prev_done = done_cyc;
      @(posedge clk);
      #1;
      acc = pcnt;
      chk(32'(tx), 32'd0, "b2b_second_start");
      chk(32'(tx_ready), 32'd0, "b2b_second_ready");
      chk(32'(acc - prev_done), 32'd2, "b2b_one_idle_clk");
      tx_valid = 1'b0;
      check_frame(8'h22, -1, 1, 16, "b2b_second");

      // Reset during data bit 2 of 0xF0 (bit index 3, mid-bit at clk 56).
      send(8'hF0, 16'd0, 2'b00, 1'b0, 1'b0);
      repeat (56) @(posedge clk);
      #1;
      chk(32'(tx), 32'd0, "f0_before_reset");
      dc_save = done_cnt;
      reset = 1'b1;
      #1;
      chk(32'(tx), 32'd1, "async_rst_tx");
      chk(32'(tx_ready), 32'd1, "async_rst_ready");
      chk(32'(tx_busy), 32'd0, "async_rst_busy");
      chk(32'(tx_done), 32'd0, "async_rst_done");
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      send(8'h3C, 16'd0, 2'b01, 1'b0, 1'b0);
      check_frame(8'h3C, 0, 1, 16, "after_reset_3c");
      chk(32'(done_cnt), 32'(dc_save + 1), "aborted_frame_no_done");

      // Config changes mid-frame leave the current frame alone.
      send(8'h07, 16'd1, 2'b01, 1'b0, 1'b0);
      fork
         begin
            repeat (40) @(posedge clk);
            #2;
            divisor     = 16'd0;
            parity_mode = 2'b10;
            stop2       = 1'b1;
            tx_data     = 8'hFF;
         end
      join_none
      check_frame(8'h07, 1, 1, 32, "midcfg_frame");
      send(8'h07, 16'd0, 2'b10, 1'b1, 1'b0);
      check_frame(8'h07, 0, 2, 16, "newcfg_frame");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
